// File: rtl/mito_acc_if.sv
// rtl/mito_acc_if.sv - host/engine handshake bundle for the MITO compute engine
// Purpose: groups job control, input word stream and result stream of mito_acc_engine.
// Signals:
//   start/mode/num_out   job launch (host -> engine)
//   in_valid/in_ready/in_data     element stream into the engine
//   out_valid/out_ready/out_data  result stream out of the engine
//   busy/done/err        job status (engine -> host)
// Modports: master = host side, slave = engine side.
interface mito_acc_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32
);
  logic                 start;
  logic [1:0]           mode;
  logic [15:0]          num_out;
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, mode, num_out, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done, err
  );

  modport slave (
    input  start, mode, num_out, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done, err
  );
endinterface

// File: rtl/mito_acc_engine.sv
// rtl/mito_acc_engine.sv - single-lane MAC / bias / activation / max-pool engine
// Purpose: streams ifm, weight and bias words, accumulates NUM_CH x WIN products, adds bias,
//   requantises (shift + saturate, ReLU for convolution) or computes a POOL_N-element max.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mito_acc_if.slave: start/mode/num_out, in_* stream, out_* stream, busy/done/err
module mito_acc_engine #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int DATA_WIDTH = 8,
  parameter int WIN        = 9,
  parameter int NUM_CH     = 1,
  parameter int POOL_N     = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int SHIFT      = 0
) (
  input logic       clk,
  input logic       rst_n,
  mito_acc_if.slave bus
);

  localparam logic [1:0] MODE_CONV  = 2'b01;
  localparam logic [1:0] MODE_FULLY = 2'b10;
  localparam logic [1:0] MODE_POOL  = 2'b11;

  // One tap counter serves both the MAC window and the pool window.
  localparam int CNT_MAX = (WIN > POOL_N) ? WIN : POOL_N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int CH_W    = $clog2(NUM_CH + 1);
  localparam int PROD_W  = 2 * DATA_WIDTH;

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN - 1);
  localparam logic [CNT_W-1:0] POOL_LAST = CNT_W'(POOL_N - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [2:0] {
    S_IDLE, S_LD_IFM, S_LD_WGT, S_LD_BIAS, S_ACT, S_OUT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]                   mode_q;
  logic [15:0]                  num_out_q;
  logic [15:0]                  out_cnt;
  logic [CNT_W-1:0]             tap;
  logic [CH_W-1:0]              ch;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH-1:0] ifm_buf [WIN];
  logic signed [DATA_WIDTH-1:0] pmax;
  logic [OUT_WIDTH-1:0]         out_q;
  logic                         err_q;

  logic                         in_fire, out_fire;
  logic                         is_pool, ifm_last, wgt_last, ch_last, out_last;
  logic [IDX_W-1:0]             tap_idx;
  logic signed [DATA_WIDTH-1:0] elem;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext, bias_ext, shifted;
  logic signed [DATA_WIDTH-1:0] act_res;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  assign elem     = bus.in_data[DATA_WIDTH-1:0];
  assign is_pool  = (mode_q == MODE_POOL);
  assign ifm_last = (tap == (is_pool ? POOL_LAST : WIN_LAST));
  assign wgt_last = (tap == WIN_LAST);
  assign ch_last  = (ch == CH_LAST);
  assign out_last = ((out_cnt + 16'd1) == num_out_q);
  assign tap_idx  = IDX_W'(tap);

  // Full-precision product and bias, sign-extended into the accumulator width.
  assign prod     = ifm_buf[tap_idx] * elem;
  assign prod_ext = {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext = {{(ACC_WIDTH - DATA_WIDTH){elem[DATA_WIDTH-1]}}, elem};
  assign shifted  = acc >>> SHIFT;

  generate
    if (IN_WIDTH > DATA_WIDTH) begin : g_in_upper
      logic unused_in_upper;
      assign unused_in_upper = ^bus.in_data[IN_WIDTH-1:DATA_WIDTH];
    end
  endgenerate

  assign bus.in_ready  = (state == S_LD_IFM) || (state == S_LD_WGT) || (state == S_LD_BIAS);
  assign bus.out_valid = (state == S_OUT);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.err       = err_q;
  assign bus.out_data  = out_q;

  // Requantisation: pool passes the max through unshifted; the others saturate.
  always_comb begin
    act_res = '0;
    case (mode_q)
      MODE_POOL: act_res = pmax;
      MODE_CONV: begin
        if (shifted < 0)             act_res = '0;
        else if (shifted > SAT_MAX)  act_res = DATA_WIDTH'(SAT_MAX);
        else                         act_res = DATA_WIDTH'(shifted);
      end
      MODE_FULLY: begin
        if (shifted < SAT_MIN)       act_res = DATA_WIDTH'(SAT_MIN);
        else if (shifted > SAT_MAX)  act_res = DATA_WIDTH'(SAT_MAX);
        else                         act_res = DATA_WIDTH'(shifted);
      end
      default: act_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start && bus.mode != 2'b00)
          state_nxt = (bus.num_out == 16'd0) ? S_DONE : S_LD_IFM;
      end
      S_LD_IFM: begin
        if (in_fire && ifm_last) state_nxt = is_pool ? S_ACT : S_LD_WGT;
      end
      S_LD_WGT: begin
        if (in_fire && wgt_last) state_nxt = ch_last ? S_LD_BIAS : S_LD_IFM;
      end
      S_LD_BIAS: begin
        if (in_fire) state_nxt = S_ACT;
      end
      S_ACT:   state_nxt = S_OUT;
      S_OUT: begin
        if (out_fire) state_nxt = out_last ? S_DONE : S_LD_IFM;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 2'b00;
      num_out_q <= '0;
      out_cnt   <= '0;
      tap       <= '0;
      ch        <= '0;
      acc       <= '0;
      pmax      <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < WIN; i++) ifm_buf[i] <= '0;
    end else begin
      err_q <= (state == S_IDLE) && bus.start && (bus.mode == 2'b00);
      case (state)
        S_IDLE: begin
          if (bus.start && bus.mode != 2'b00) begin
            mode_q    <= bus.mode;
            num_out_q <= bus.num_out;
            out_cnt   <= '0;
            tap       <= '0;
            ch        <= '0;
            acc       <= '0;
          end
        end
        S_LD_IFM: begin
          if (in_fire) begin
            if (!is_pool) ifm_buf[tap_idx] <= elem;
            // First element of a pool window seeds the running max.
            if (tap == '0 || elem > pmax) pmax <= elem;
            tap <= ifm_last ? '0 : tap + 1'b1;
          end
        end
        S_LD_WGT: begin
          if (in_fire) begin
            acc <= acc + prod_ext;
            if (wgt_last) begin
              tap <= '0;
              if (!ch_last) ch <= ch + 1'b1;
            end else begin
              tap <= tap + 1'b1;
            end
          end
        end
        S_LD_BIAS: begin
          if (in_fire) acc <= acc + bias_ext;
        end
        S_ACT: out_q <= {{(OUT_WIDTH - DATA_WIDTH){act_res[DATA_WIDTH-1]}}, act_res};
        S_OUT: begin
          if (out_fire) begin
            out_cnt <= out_cnt + 16'd1;
            acc     <= '0;
            ch      <= '0;
            tap     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
